uart_rx_ext: RTL and testbench
==============================

Name: uart_rx_ext

Overview:
- Parametrised successor to the single-byte UART receiver.
- Runtime-configurable frame: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits.
- Improves sampling robustness with 3-sample majority voting.
- Flags parity, framing and break errors per character and buffers received characters in a first-word-fall-through (FWFT) FIFO with a valid/ready output handshake and sticky overrun. Sits between the pad-side serial input and the UART register/TL-UL wrapper.

Parameters:
- CNT_W, 16, width of clks_per_bit_i and the bit-period counter.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, ≥2.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- rx_i  in  1  asynchronous serial input, idle high
- en_i  in  1  receiver enable
- clks_per_bit_i  in  CNT_W  clk_i cycles per bit; legal ≥4
- data_bits_i  in  2  0=5, 1=6, 2=7, 3=8 data bits
- parity_en_i  in  1  parity bit present
- parity_odd_i  in  1  1=odd, 0=even parity
- stop2_i  in  1  1=two stop bits
- sbit_o  out  1  one-cycle pulse on accepted start-bit edge
- busy_o  out  1  frame in progress (state ≠ IDLE)
- rx_valid_o  out  1  FIFO head valid
- rx_ready_i  in  1  consumer pops head when valid&ready
- rx_data_o  out  8  head data, unused MSBs zero
- rx_perr_o  out  1  head parity error
- rx_ferr_o  out  1  head framing error
- rx_brk_o  out  1  head break condition
- ovr_o  out  1  sticky overrun
- ovr_clr_i  in  1  clears ovr_o

Behaviour:
- Reset (rst_i=1 at clk_i edge): synchroniser flops=1, state=IDLE, counters=0, FIFO empty. All outputs 0 (rx_data_o=0).
- rx_i passes through 2 flops (sync_rx); all decisions use sync_rx.
- Config latch: data_bits/parity/stop2/clks_per_bit are captured on the IDLE→START transition. Mid-frame input changes have no effect.
- Bit windows: counter cnt runs 0..clks_per_bit-1 per bit window, wrapping to 0 at the next bit. The start window begins (cnt=0) in the cycle after sync_rx=0 is seen in IDLE.
- Majority vote: with H=clks_per_bit>>1, sync_rx is sampled at cnt=H-1, H, H+1. The bit value is the majority of the three samples, decided at cnt=H+1.
- States:
  - IDLE: if en_i & sync_rx==0 → START; sbit_o=1 for that cycle.
  - START: at decision, majority 1 → IDLE (false start, nothing pushed); 0 → DATA.
  - DATA: LSB first into shift register, N=5..8 bits → PARITY if enabled, else STOP.
  - PARITY: perr = XOR(data bits, parity bit) ≠ parity_odd.
  - STOP: one or two windows; ferr set if any stop majority=0. At decision of the last stop bit, push entry and go → IDLE if sync_rx==1, else → WAIT_HIGH.
  - WAIT_HIGH: stay until sync_rx==1, then → IDLE. No new start detected while line held low.
- Early return: return happens at cnt=H+1 of the last stop bit (not end of window), allowing resync to a back-to-back start bit.
- Break: all data, parity (if present) and first stop majorities are 0 → brk=1, ferr=1, data=0.
- en_i=0: the next edge forces IDLE, aborts any frame (no push); FIFO contents and ovr_o are retained.
- FIFO:
  - Entry = {brk, ferr, perr, data[7:0]}.
  - FWFT: rx_valid_o and head fields update the cycle after the push edge.
  - Pop on rx_valid_o&rx_ready_i. Push and pop in the same cycle are both honoured, including when full; count is unchanged.
  - Push while full with no pop: entry dropped, ovr_o=1 next cycle. ovr_o stays set until ovr_clr_i. If ovr_clr_i and a new overrun occur in the same cycle, set wins.
  - Pointers wrap modulo FIFO_DEPTH.
- Counter width CNT_W; no overflow because cnt < clks_per_bit_i.

Test Plan:
- clks_per_bit=16, 8N1, rx sends 0xA5 → sbit_o pulse. rx_valid_o rises one cycle after the stop-bit decision. rx_data_o=0xA5, perr=ferr=brk=0; pop clears valid.
- 7E2, 0x35 with correct parity, then 0x35 with parity bit inverted → entries 0x35/perr=0 then 0x35/perr=1. 5O1, 0x1F → rx_data_o=0x1F, perr=0.
- Start glitch low for 3 cycles (clks_per_bit=16) → returns to IDLE, no push. Single-cycle glitch at cnt=H in a data bit → majority ignores it, byte correct.
- Stop bit driven 0 → ferr=1 with data. Line held low 12 bit times → one entry, brk=1, ferr=1, data=0x00. busy_o stays high in WAIT_HIGH until the line is released; no second entry.
- FIFO_DEPTH=4, rx_ready_i=0, 5 frames 0x01..0x05 → 4 entries 0x01..0x04, ovr_o=1. ovr_clr_i clears it. Full FIFO with push+pop in the same cycle → no overrun, order preserved.
- rst_i asserted mid-DATA and en_i dropped mid-frame → all outputs 0 after reset. After en_i drop: no partial entry, existing FIFO entries intact. The next frame after re-enable is received correctly.

Source files
------------

// File: rtl/uart_rx_ext.sv
// Configurable UART receiver: 5-8 data bits, optional even/odd parity,
// 1 or 2 stop bits, 3-sample majority voting, per-character error flags
// and a first-word-fall-through receive FIFO with sticky overrun.
module uart_rx_ext #(
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rx_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] clks_per_bit_i,
    input  logic [1:0]       data_bits_i,
    input  logic             parity_en_i,
    input  logic             parity_odd_i,
    input  logic             stop2_i,
    output logic             sbit_o,
    output logic             busy_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_perr_o,
    output logic             rx_ferr_o,
    output logic             rx_brk_o,
    output logic             ovr_o,
    input  logic             ovr_clr_i
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   FCNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    // ---------------------------------------------------------------
    // Receiver state
    // ---------------------------------------------------------------
    logic             sync_meta_reg, sync_rx_reg;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] cpb_reg, cpb_next;
    logic [1:0]       dbits_reg, dbits_next;
    logic             par_en_reg, par_en_next;
    logic             par_odd_reg, par_odd_next;
    logic             stop2_reg, stop2_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic             stop_idx_reg, stop_idx_next;
    logic [1:0]       samp_reg, samp_next;
    logic [7:0]       shift_reg, shift_next;
    logic             perr_reg, perr_next;
    logic             ferr_reg, ferr_next;
    logic             brk_reg, brk_next;
    logic             all_zero_reg, all_zero_next;

    logic             push;
    logic [10:0]      push_word;
    logic             sbit;
    logic             ferr_now, brk_now;

    logic [CNT_W-1:0] half, half_m1, half_p1;
    logic             in_frame, decide, vote, last_cnt;

    assign half     = cpb_reg >> 1;
    assign half_m1  = half - CNT_ONE;
    assign half_p1  = half + CNT_ONE;
    assign last_cnt = (cnt_reg == cpb_reg - CNT_ONE);
    assign in_frame = (state_reg == ST_START) || (state_reg == ST_DATA) ||
                      (state_reg == ST_PARITY) || (state_reg == ST_STOP);
    assign decide   = in_frame && (cnt_reg == half_p1);
    // Third sample is the live synchronised line at the decision point
    assign vote     = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & sync_rx_reg) |
                      (samp_reg[1] & sync_rx_reg);

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_meta_reg <= 1'b1;
            sync_rx_reg   <= 1'b1;
        end else begin
            sync_meta_reg <= rx_i;
            sync_rx_reg   <= sync_meta_reg;
        end
    end

    // Frame state register and latched per-frame configuration
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            cpb_reg      <= '0;
            dbits_reg    <= '0;
            par_en_reg   <= 1'b0;
            par_odd_reg  <= 1'b0;
            stop2_reg    <= 1'b0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            samp_reg     <= '0;
            shift_reg    <= '0;
            perr_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
            brk_reg      <= 1'b0;
            all_zero_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            cpb_reg      <= cpb_next;
            dbits_reg    <= dbits_next;
            par_en_reg   <= par_en_next;
            par_odd_reg  <= par_odd_next;
            stop2_reg    <= stop2_next;
            bit_idx_reg  <= bit_idx_next;
            stop_idx_reg <= stop_idx_next;
            samp_reg     <= samp_next;
            shift_reg    <= shift_next;
            perr_reg     <= perr_next;
            ferr_reg     <= ferr_next;
            brk_reg      <= brk_next;
            all_zero_reg <= all_zero_next;
        end
    end

    // Next-state logic: bit timing, majority sampling, error flags and push
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        cpb_next      = cpb_reg;
        dbits_next    = dbits_reg;
        par_en_next   = par_en_reg;
        par_odd_next  = par_odd_reg;
        stop2_next    = stop2_reg;
        bit_idx_next  = bit_idx_reg;
        stop_idx_next = stop_idx_reg;
        samp_next     = samp_reg;
        shift_next    = shift_reg;
        perr_next     = perr_reg;
        ferr_next     = ferr_reg;
        brk_next      = brk_reg;
        all_zero_next = all_zero_reg;
        push          = 1'b0;
        push_word     = {brk_reg, ferr_reg, perr_reg, shift_reg};
        sbit          = 1'b0;
        ferr_now      = ferr_reg;
        brk_now       = brk_reg;

        if (in_frame) begin
            cnt_next = last_cnt ? '0 : cnt_reg + CNT_ONE;
            if (cnt_reg == half_m1) samp_next[0] = sync_rx_reg;
            if (cnt_reg == half)    samp_next[1] = sync_rx_reg;
        end

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (en_i && !sync_rx_reg) begin
                    state_next    = ST_START;
                    sbit          = 1'b1;
                    cpb_next      = clks_per_bit_i;
                    dbits_next    = data_bits_i;
                    par_en_next   = parity_en_i;
                    par_odd_next  = parity_odd_i;
                    stop2_next    = stop2_i;
                    bit_idx_next  = '0;
                    stop_idx_next = 1'b0;
                    shift_next    = '0;
                    perr_next     = 1'b0;
                    ferr_next     = 1'b0;
                    brk_next      = 1'b0;
                    all_zero_next = 1'b1;
                end
            end
            ST_START: begin
                if (decide) begin
                    if (vote) begin
                        // False start: glitch shorter than half a bit
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shift_next[bit_idx_reg] = vote;
                    if (vote) all_zero_next = 1'b0;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == ({1'b0, dbits_reg} + 3'd4))
                        state_next = par_en_reg ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (decide) begin
                    perr_next = ((^shift_reg) ^ vote) != par_odd_reg;
                    if (vote) all_zero_next = 1'b0;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    // Break is judged on the first stop bit only
                    brk_now   = (stop_idx_reg == 1'b0) ? (all_zero_reg & ~vote) : brk_reg;
                    ferr_now  = ferr_reg | ~vote | brk_now;
                    ferr_next = ferr_now;
                    brk_next  = brk_now;
                    if (stop_idx_reg == stop2_reg) begin
                        // Return early so a back-to-back start bit is caught
                        push       = 1'b1;
                        push_word  = {brk_now, ferr_now, perr_reg, brk_now ? 8'h00 : shift_reg};
                        state_next = sync_rx_reg ? ST_IDLE : ST_WAIT_HIGH;
                        cnt_next   = '0;
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                cnt_next = '0;
                if (sync_rx_reg) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        // Disabling the receiver aborts the frame without pushing anything
        if (!en_i) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            push       = 1'b0;
        end
    end

    assign sbit_o = sbit;
    assign busy_o = (state_reg != ST_IDLE);

    // ---------------------------------------------------------------
    // Receive FIFO (first-word-fall-through)
    // ---------------------------------------------------------------
    logic [10:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             ovr_reg;
    logic             fifo_full, fifo_valid, pop, wr_en, overrun;
    logic [10:0]      head;

    assign fifo_full  = (count_reg == FULL_CNT);
    assign fifo_valid = (count_reg != '0);
    assign pop        = fifo_valid & rx_ready_i;
    // When full, a simultaneous pop frees the slot the write lands in
    assign wr_en      = push & (~fifo_full | pop);
    assign overrun    = push & fifo_full & ~pop;
    assign head       = mem[rd_ptr_reg];

    // Storage write; contents need no reset since reads are gated by count
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr_reg] <= push_word;
    end

    // Pointer, occupancy and sticky overrun bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovr_reg    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + FCNT_ONE;
                2'b01:   count_reg <= count_reg - FCNT_ONE;
                default: count_reg <= count_reg;
            endcase
            if (overrun)        ovr_reg <= 1'b1;
            else if (ovr_clr_i) ovr_reg <= 1'b0;
        end
    end

    assign rx_valid_o = fifo_valid;
    assign rx_data_o  = fifo_valid ? head[7:0] : 8'h00;
    assign rx_perr_o  = fifo_valid & head[8];
    assign rx_ferr_o  = fifo_valid & head[9];
    assign rx_brk_o   = fifo_valid & head[10];
    assign ovr_o      = ovr_reg;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed testbench for uart_rx_ext: frame formats, glitch rejection,
// framing/break errors, FIFO overrun and abort/reset behaviour.
module tb_uart_rx_ext;

    localparam int CPB = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rx_i;
    logic        en_i;
    logic [15:0] clks_per_bit_i;
    logic [1:0]  data_bits_i;
    logic        parity_en_i;
    logic        parity_odd_i;
    logic        stop2_i;
    logic        sbit_o;
    logic        busy_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic [7:0]  rx_data_o;
    logic        rx_perr_o;
    logic        rx_ferr_o;
    logic        rx_brk_o;
    logic        ovr_o;
    logic        ovr_clr_i;

    uart_rx_ext #(.CNT_W(16), .FIFO_DEPTH(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rx_i           (rx_i),
        .en_i           (en_i),
        .clks_per_bit_i (clks_per_bit_i),
        .data_bits_i    (data_bits_i),
        .parity_en_i    (parity_en_i),
        .parity_odd_i   (parity_odd_i),
        .stop2_i        (stop2_i),
        .sbit_o         (sbit_o),
        .busy_o         (busy_o),
        .rx_valid_o     (rx_valid_o),
        .rx_ready_i     (rx_ready_i),
        .rx_data_o      (rx_data_o),
        .rx_perr_o      (rx_perr_o),
        .rx_ferr_o      (rx_ferr_o),
        .rx_brk_o       (rx_brk_o),
        .ovr_o          (ovr_o),
        .ovr_clr_i      (ovr_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int   cyc = 0;
    int   sbit_cnt = 0;
    int   rise_cyc = -1;
    int   start_cyc = 0;
    logic prev_valid = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk_i) cyc++;

    // Observe sbit pulses and the first cycle rx_valid_o is seen high
    always @(negedge clk_i) begin
        if (sbit_o) sbit_cnt++;
        if (rx_valid_o && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_valid_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got 0x%0h ok", tag, got);
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Head word compared as {valid, brk, ferr, perr, data}
    task automatic check_head(input string tag, input logic [7:0] d,
                              input logic p, input logic f, input logic b);
        check(tag, {20'd0, rx_valid_o, rx_brk_o, rx_ferr_o, rx_perr_o, rx_data_o},
                   {20'd0, 1'b1, b, f, p, d});
    endtask

    task automatic pop_head();
        rx_ready_i = 1'b1;
        @(negedge clk_i);
        rx_ready_i = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] db, input logic pen, input logic podd, input logic s2);
        data_bits_i  = db;
        parity_en_i  = pen;
        parity_odd_i = podd;
        stop2_i      = s2;
    endtask

    // Drive one frame using the current configuration. gbit/gpos invert a
    // single cycle of one bit (bit 0 = start); max_cyc truncates the frame;
    // pop_at raises rx_ready_i for exactly one cycle at that frame offset.
    task automatic send_frame(input logic [7:0] d, input int gbit = -1, input int gpos = -1,
                              input logic stop_val = 1'b1, input logic flip_par = 1'b0,
                              input int max_cyc = 100000, input int pop_at = -1);
        logic bits [12];
        logic [7:0] mask;
        int nb, n, rel;
        nb   = int'(data_bits_i) + 5;
        mask = 8'hFF >> (8 - nb);
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nb; i++) begin bits[n] = d[i]; n++; end
        if (parity_en_i) begin bits[n] = (^(d & mask)) ^ parity_odd_i ^ flip_par; n++; end
        for (int s = 0; s < (stop2_i ? 2 : 1); s++) begin bits[n] = stop_val; n++; end
        start_cyc = cyc;
        rel = 0;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (rel >= max_cyc) return;
                rx_i = (b == gbit && c == gpos) ? ~bits[b] : bits[b];
                if (pop_at >= 0) rx_ready_i = (rel == pop_at);
                @(negedge clk_i);
                rel++;
            end
        end
        rx_i = 1'b1;
        if (pop_at >= 0) rx_ready_i = 1'b0;
        repeat (2 * CPB) @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1; rx_i = 1'b1; en_i = 1'b1; clks_per_bit_i = 16'(CPB);
        rx_ready_i = 1'b0; ovr_clr_i = 1'b0;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Reset state
        check("rst_valid", rx_valid_o, 0);
        check("rst_data",  rx_data_o, 0);
        check("rst_busy",  busy_o, 0);
        check("rst_ovr",   ovr_o, 0);
        check("rst_flags", {rx_perr_o, rx_ferr_o, rx_brk_o, sbit_o}, 0);

        // 8N1 0xA5: one sbit pulse, valid 157 cycles after the start edge
        sbit_cnt = 0; rise_cyc = -1;
        send_frame(8'hA5);
        check("a5_sbit", sbit_cnt, 1);
        check("a5_latency", rise_cyc - start_cyc, 157);
        check_head("a5_head", 8'hA5, 1'b0, 1'b0, 1'b0);
        pop_head();
        check("a5_popped", rx_valid_o, 0);

        // 7E2 0x35 good parity then bad parity
        set_cfg(2'd2, 1'b1, 1'b0, 1'b1);
        send_frame(8'h35);
        send_frame(8'h35, -1, -1, 1'b1, 1'b1);
        check_head("7e2_good", 8'h35, 1'b0, 1'b0, 1'b0);
        pop_head();
        check_head("7e2_bad", 8'h35, 1'b1, 1'b0, 1'b0);
        pop_head();

        // 5O1 0x1F
        set_cfg(2'd0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h1F);
        check_head("5o1", 8'h1F, 1'b0, 1'b0, 1'b0);
        pop_head();

        // Start glitch of 3 cycles is rejected
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        rx_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (2 * CPB) @(negedge clk_i);
        check("glitch_start_v", rx_valid_o, 0);
        check("glitch_start_b", busy_o, 0);

        // One-cycle glitch at the middle sample of data bit 3
        send_frame(8'hA5, 4, 9);
        check_head("glitch_data", 8'hA5, 1'b0, 1'b0, 1'b0);
        pop_head();

        // Stop bit low -> framing error with data
        send_frame(8'h3C, -1, -1, 1'b0);
        check_head("ferr", 8'h3C, 1'b0, 1'b1, 1'b0);
        pop_head();

        // Line held low 12 bit times -> single break entry
        rx_i = 1'b0;
        repeat (12 * CPB) @(negedge clk_i);
        check("brk_busy_low", busy_o, 1);
        rx_i = 1'b1;
        repeat (2 * CPB) @(negedge clk_i);
        check("brk_busy_rel", busy_o, 0);
        check_head("brk", 8'h00, 1'b0, 1'b1, 1'b1);
        pop_head();
        check("brk_single", rx_valid_o, 0);

        // Overrun: five frames into a four-entry FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i));
        check("ovr_set", ovr_o, 1);
        ovr_clr_i = 1'b1;
        @(negedge clk_i);
        ovr_clr_i = 1'b0;
        check("ovr_clr", ovr_o, 0);
        for (int i = 1; i <= 4; i++) begin
            check_head($sformatf("ovr_q%0d", i), 8'(i), 1'b0, 1'b0, 1'b0);
            pop_head();
        end
        check("ovr_empty", rx_valid_o, 0);

        // Full FIFO, push and pop in the same cycle
        for (int i = 1; i <= 4; i++) send_frame(8'h10 + 8'(i));
        send_frame(8'h15, -1, -1, 1'b1, 1'b0, 100000, 156);
        check("pp_no_ovr", ovr_o, 0);
        for (int i = 2; i <= 5; i++) begin
            check_head($sformatf("pp_q%0d", i), 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
            pop_head();
        end
        check("pp_empty", rx_valid_o, 0);

        // Reset in the middle of DATA clears everything
        send_frame(8'h77);
        check("pre_rst_valid", rx_valid_o, 1);
        send_frame(8'h3C, -1, -1, 1'b1, 1'b0, 60);
        check("mid_busy", busy_o, 1);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        rx_i = 1'b1;
        @(negedge clk_i);
        check("mrst_valid", rx_valid_o, 0);
        check("mrst_data",  rx_data_o, 0);
        check("mrst_busy",  busy_o, 0);
        check("mrst_flags", {ovr_o, rx_perr_o, rx_ferr_o, rx_brk_o}, 0);

        // en_i dropped mid-frame: no partial entry, old entry kept
        send_frame(8'h5A);
        send_frame(8'hC3, -1, -1, 1'b1, 1'b0, 60);
        en_i = 1'b0;
        @(negedge clk_i);
        check("en_abort_busy", busy_o, 0);
        rx_i = 1'b1;
        repeat (3 * CPB) @(negedge clk_i);
        check_head("en_keep", 8'h5A, 1'b0, 1'b0, 1'b0);
        pop_head();
        check("en_no_partial", rx_valid_o, 0);
        en_i = 1'b1;
        repeat (CPB) @(negedge clk_i);
        send_frame(8'h96);
        check_head("en_resume", 8'h96, 1'b0, 1'b0, 1'b0);
        pop_head();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
